imem_resp: RTL

IMEM_RESP -- requirements
Module: imem_resp

---
 rtl/imem_resp.sv | 119 +++++++++++
 1 files changed

// File: rtl/imem_resp.sv
// Instruction/data memory responder with fixed-latency done handshake.
// Three-state FSM; faulted requests complete with err and no side effects.
module imem_resp #(
  parameter int LATENCY = 2,
  parameter int AW      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic        rd,
  input  logic        wr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        done,
  output logic        stall,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  localparam logic [3:0] LOAD = 4'(LATENCY - 1);
  localparam bit         ONE  = (LATENCY == 1);

  state_t        state;
  logic [3:0]    cnt;
  logic [AW-1:0] q_idx;
  logic [15:0]   q_data;
  logic          q_rd;
  logic          q_wr;
  logic          q_odd;
  logic [15:0]   mem [2**AW];

  logic          accept;
  logic          now;
  logic          fin;
  logic [AW-1:0] c_idx;
  logic [15:0]   c_data;
  logic          c_rd;
  logic          c_wr;
  logic          c_fault;
  logic          c_we;
  logic          c_re;

  // With LATENCY=1 the completing request is the one arriving this edge.
  always_comb begin
    accept  = (state == IDLE || state == DONE) && (rd || wr);
    now     = (state != WAIT);
    fin     = now ? (accept && ONE) : (cnt == 4'd1);
    c_idx   = now ? addr[AW:1] : q_idx;
    c_data  = now ? data_in : q_data;
    c_rd    = now ? rd : q_rd;
    c_wr    = now ? wr : q_wr;
    c_fault = (now ? addr[0] : q_odd) | (c_rd & c_wr);
    c_we    = fin & c_wr & ~c_fault;
    c_re    = fin & c_rd & ~c_fault;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      done     <= 1'b0;
      stall    <= 1'b0;
      err      <= 1'b0;
      data_out <= '0;
      q_idx    <= '0;
      q_data   <= '0;
      q_rd     <= 1'b0;
      q_wr     <= 1'b0;
      q_odd    <= 1'b0;
    end else begin
      done  <= fin;
      err   <= fin & c_fault;
      stall <= (state == WAIT && cnt != 4'd1) ||
               (accept && !ONE);
      if (fin) begin
        data_out <= c_re ? mem[c_idx] : '0;
      end
      if (accept) begin
        q_idx  <= addr[AW:1];
        q_data <= data_in;
        q_rd   <= rd;
        q_wr   <= wr;
        q_odd  <= addr[0];
      end
      unique case (state)
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= DONE;
          end
        end
        default: begin
          if (accept) begin
            state <= ONE ? DONE : WAIT;
            cnt   <= LOAD;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**AW; i++) begin
        mem[i] <= '0;
      end
    end else if (c_we) begin
      mem[c_idx] <= c_data;
    end
  end

endmodule
